// File: rtl/bus_write_bank.sv
// Write side of the shared datapath bus: code-decoded register loads plus a req/ack data-memory write.
// Optional macro DM_TIMEOUT_EN adds a REQ-state timeout that abandons an unacknowledged write.
//
// state | meaning
// IDLE  | no DM write outstanding; code 12 latches address/data and starts a request
// REQ   | dm_wr_req held with stable addr/data until dm_wr_ack (or timeout)
module bus_write_bank #(
  parameter int DATA_W         = 16,
  parameter int DM_W           = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        write_en,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] dar,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DM_W-1:0]   dm_wdata,
  output logic              dm_wr_req,
  input  logic              dm_wr_ack,
  output logic              busy,
  output logic              wr_err
);

  localparam logic [3:0] CODE_PC  = 4'd1;
  localparam logic [3:0] CODE_DAR = 4'd2;
  localparam logic [3:0] CODE_IR  = 4'd4;
  localparam logic [3:0] CODE_AC  = 4'd5;
  localparam logic [3:0] CODE_R   = 4'd6;
  localparam logic [3:0] CODE_R1  = 4'd7;
  localparam logic [3:0] CODE_R2  = 4'd8;
  localparam logic [3:0] CODE_R3  = 4'd9;
  localparam logic [3:0] CODE_R4  = 4'd10;
  localparam logic [3:0] CODE_R5  = 4'd11;
  localparam logic [3:0] CODE_DM  = 4'd12;

  typedef enum logic {ST_IDLE, ST_REQ} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, dar_q, ir_q, ac_q, r_q, r1_q, r2_q, r3_q, r4_q, r5_q;
  logic [DATA_W-1:0] dm_addr_q, dm_addr_d;
  logic [DM_W-1:0]   dm_wdata_q, dm_wdata_d;
  logic              wr_err_q, wr_err_d;
  logic              code_illegal;

  // 3 and 14/15 are reserved, 13 is the read-only instruction memory.
  assign code_illegal = (write_en == 4'd3) || (write_en >= 4'd13);

`ifdef DM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      dar_q <= '0;
      ir_q  <= '0;
      ac_q  <= '0;
      r_q   <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
    end else begin
      // An explicit PC load beats the increment issued in the same cycle.
      if (write_en == CODE_PC) pc_q <= bus_in;
      else if (pc_inc)         pc_q <= pc_q + DATA_W'(1);
      case (write_en)
        CODE_DAR: dar_q <= bus_in;
        CODE_IR:  ir_q  <= bus_in;
        CODE_AC:  ac_q  <= bus_in;
        CODE_R:   r_q   <= bus_in;
        CODE_R1:  r1_q  <= bus_in;
        CODE_R2:  r2_q  <= bus_in;
        CODE_R3:  r3_q  <= bus_in;
        CODE_R4:  r4_q  <= bus_in;
        CODE_R5:  r5_q  <= bus_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    wr_err_d   = code_illegal;
`ifdef DM_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif
    if (state_q == ST_IDLE) begin
      if (write_en == CODE_DM) begin
        state_d    = ST_REQ;
        dm_addr_d  = dar_q;
        dm_wdata_d = bus_in[DM_W-1:0];
`ifdef DM_TIMEOUT_EN
        tmr_d      = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
      end
    end else begin
      if (write_en == CODE_DM) wr_err_d = 1'b1;
      if (dm_wr_ack) begin
        state_d = ST_IDLE;
      end
`ifdef DM_TIMEOUT_EN
      else if (tmr_q == '0) begin
        state_d  = ST_IDLE;
        wr_err_d = 1'b1;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      wr_err_q   <= wr_err_d;
    end
  end

`ifdef DM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_q <= '0;
    else        tmr_q <= tmr_d;
  end
`endif

  assign pc        = pc_q;
  assign dar       = dar_q;
  assign ir        = ir_q;
  assign ac        = ac_q;
  assign r         = r_q;
  assign r1        = r1_q;
  assign r2        = r2_q;
  assign r3        = r3_q;
  assign r4        = r4_q;
  assign r5        = r5_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  // Decoded straight from the state flop so reset drops the request without a clock edge.
  assign dm_wr_req = (state_q == ST_REQ);
  assign busy      = (state_q == ST_REQ);
  assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_bus_write_bank.sv
// Directed bench for bus_write_bank: register vector table plus hand-written DM handshake sequences.
module tb_bus_write_bank;

  logic        clk, rst_n;
  logic [3:0]  write_en;
  logic [15:0] bus_in;
  logic        pc_inc, dm_wr_ack;
  logic [15:0] pc, dar, ir, ac, r, r1, r2, r3, r4, r5, dm_addr;
  logic [7:0]  dm_wdata;
  logic        dm_wr_req, busy, wr_err;

  int total = 0;
  int bad   = 0;

  bus_write_bank dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .bus_in(bus_in), .pc_inc(pc_inc),
    .pc(pc), .dar(dar), .ir(ir), .ac(ac), .r(r), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr_req(dm_wr_req), .dm_wr_ack(dm_wr_ack),
    .busy(busy), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  we;
    logic [15:0] bus;
    logic        inc;
    logic [3:0]  sel;
    logic [15:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] reg_sel(input logic [3:0] sel);
    case (sel)
      4'd0: return pc;
      4'd1: return dar;
      4'd2: return ir;
      4'd3: return ac;
      4'd4: return r;
      4'd5: return r1;
      4'd6: return r2;
      4'd7: return r3;
      4'd8: return r4;
      default: return r5;
    endcase
  endfunction

  task automatic step(input logic [3:0] we, input logic [15:0] bus, input logic inc,
                      input logic ack);
    write_en  = we;
    bus_in    = bus;
    pc_inc    = inc;
    dm_wr_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_regs(input string tag, input logic [15:0] e_pc, input logic [15:0] e_dar);
    chk({tag, " pc"},  pc,  e_pc);
    chk({tag, " dar"}, dar, e_dar);
    chk({tag, " ir"},  ir,  16'h1111);
    chk({tag, " ac"},  ac,  16'h2222);
    chk({tag, " r"},   r,   16'h3333);
    chk({tag, " r1"},  r1,  16'h0011);
    chk({tag, " r2"},  r2,  16'h0022);
    chk({tag, " r3"},  r3,  16'h0033);
    chk({tag, " r4"},  r4,  16'h0044);
    chk({tag, " r5"},  r5,  16'h0055);
  endtask

  initial begin
    int errs;
    int req_cycles;
    int d;

    vecs[0]  = '{4'd2,  16'h0040, 1'b0, 4'd1, 16'h0040, 1'b0};
    vecs[1]  = '{4'd4,  16'h1111, 1'b0, 4'd2, 16'h1111, 1'b0};
    vecs[2]  = '{4'd5,  16'h2222, 1'b0, 4'd3, 16'h2222, 1'b0};
    vecs[3]  = '{4'd6,  16'h3333, 1'b0, 4'd4, 16'h3333, 1'b0};
    vecs[4]  = '{4'd7,  16'h0011, 1'b0, 4'd5, 16'h0011, 1'b0};
    vecs[5]  = '{4'd8,  16'h0022, 1'b0, 4'd6, 16'h0022, 1'b0};
    vecs[6]  = '{4'd9,  16'h0033, 1'b0, 4'd7, 16'h0033, 1'b0};
    vecs[7]  = '{4'd10, 16'h0044, 1'b0, 4'd8, 16'h0044, 1'b0};
    vecs[8]  = '{4'd11, 16'h0055, 1'b0, 4'd9, 16'h0055, 1'b0};
    vecs[9]  = '{4'd1,  16'hFFFF, 1'b0, 4'd0, 16'hFFFF, 1'b0};
    vecs[10] = '{4'd0,  16'h0000, 1'b1, 4'd0, 16'h0000, 1'b0};
    vecs[11] = '{4'd1,  16'h1234, 1'b1, 4'd0, 16'h1234, 1'b0};
    vecs[12] = '{4'd0,  16'h0000, 1'b1, 4'd0, 16'h1235, 1'b0};
    vecs[13] = '{4'd3,  16'hDEAD, 1'b0, 4'd5, 16'h0011, 1'b1};
    vecs[14] = '{4'd13, 16'hDEAD, 1'b0, 4'd3, 16'h2222, 1'b1};
    vecs[15] = '{4'd14, 16'hDEAD, 1'b0, 4'd0, 16'h1235, 1'b1};
    vecs[16] = '{4'd15, 16'hDEAD, 1'b0, 4'd1, 16'h0040, 1'b1};
    vecs[17] = '{4'd0,  16'hDEAD, 1'b0, 4'd2, 16'h1111, 1'b0};

    rst_n = 1'b0; write_en = '0; bus_in = '0; pc_inc = 1'b0; dm_wr_ack = 1'b0;
    #2;
    chk("reset pc", pc, 16'h0);
    chk("reset req", dm_wr_req, 1'b0);
    chk("reset err", wr_err, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].we, vecs[i].bus, vecs[i].inc, 1'b0);
      chk($sformatf("vec%0d reg", i), reg_sel(vecs[i].sel), vecs[i].exp);
      chk($sformatf("vec%0d err", i), wr_err, vecs[i].err);
    end
    chk_all_regs("after table", 16'h1235, 16'h0040);

    // ack while idle must not start anything
    step(4'd0, 16'h0, 1'b0, 1'b1);
    chk("idle ack req", dm_wr_req, 1'b0);

    // basic DM write with ack on the third request cycle
    step(4'd12, 16'hABCD, 1'b0, 1'b0);
    chk("dm req", dm_wr_req, 1'b1);
    chk("dm busy", busy, 1'b1);
    chk("dm addr", dm_addr, 16'h0040);
    chk("dm wdata", dm_wdata, 8'hCD);
    chk("dm start err", wr_err, 1'b0);
    step(4'd0, 16'h0, 1'b0, 1'b0);
    chk("dm hold1 req", dm_wr_req, 1'b1);
    step(4'd0, 16'h0, 1'b0, 1'b0);
    chk("dm hold2 req", dm_wr_req, 1'b1);
    chk("dm hold2 addr", dm_addr, 16'h0040);
    step(4'd0, 16'h0, 1'b0, 1'b1);
    chk("dm ack req", dm_wr_req, 1'b0);
    chk("dm ack busy", busy, 1'b0);
    chk("dm ack err", wr_err, 1'b0);

    // write while busy: DAR load accepted, dm_addr frozen, illegal codes flagged
    step(4'd12, 16'h0077, 1'b0, 1'b0);
    chk("t5 wdata", dm_wdata, 8'h77);
    step(4'd2, 16'h0099, 1'b0, 1'b0);
    chk("t5 dar", dar, 16'h0099);
    chk("t5 addr frozen", dm_addr, 16'h0040);
    errs = 0;
    step(4'd12, 16'h5566, 1'b0, 1'b0);
    errs += int'(wr_err);
    chk("t5 wdata kept", dm_wdata, 8'h77);
    step(4'd13, 16'h0000, 1'b0, 1'b0);
    errs += int'(wr_err);
    step(4'd3, 16'h0000, 1'b0, 1'b0);
    errs += int'(wr_err);
    step(4'd0, 16'h0000, 1'b0, 1'b1);
    errs += int'(wr_err);
    chk("t5 err pulses", errs, 3);
    chk("t5 wdata final", dm_wdata, 8'h77);
    chk("t5 req done", dm_wr_req, 1'b0);
    step(4'd0, 16'h0000, 1'b0, 1'b0);
    chk("t5 err clear", wr_err, 1'b0);
    chk_all_regs("after dm", 16'h1235, 16'h0099);

    // unacknowledged request
    step(4'd12, 16'h00EE, 1'b0, 1'b0);
    req_cycles = 0;
    errs = 0;
    while (dm_wr_req && req_cycles < 40) begin
      req_cycles++;
      step(4'd0, 16'h0, 1'b0, 1'b0);
      errs += int'(wr_err);
    end
`ifdef DM_TIMEOUT_EN
    chk("t6 req cycles", req_cycles, 15);
    for (int k = 0; k < 3; k++) begin
      step(4'd0, 16'h0, 1'b0, 1'b1);
      errs += int'(wr_err);
    end
    chk("t6 err pulses", errs, 1);
    chk("t6 late ack req", dm_wr_req, 1'b0);
`else
    chk("t6 no timeout req cycles", req_cycles, 40);
    chk("t6 no timeout err", errs, 0);
    step(4'd0, 16'h0, 1'b0, 1'b1);
    chk("t6 ack req", dm_wr_req, 1'b0);
`endif

    // asynchronous reset mid-handshake
    step(4'd0, 16'h0, 1'b0, 1'b0);
    step(4'd12, 16'h0042, 1'b0, 1'b0);
    chk("t1 pre req", dm_wr_req, 1'b1);
    d = $urandom_range(1, 7);
    #(d);
    rst_n = 1'b0;
    #1;
    chk("t1 req", dm_wr_req, 1'b0);
    chk("t1 busy", busy, 1'b0);
    chk("t1 pc", pc, 16'h0);
    chk("t1 dar", dar, 16'h0);
    chk("t1 r5", r5, 16'h0);
    chk("t1 addr", dm_addr, 16'h0);
    chk("t1 wdata", dm_wdata, 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(4'd0, 16'h0, 1'b0, 1'b0);
    chk("t1 no retry", dm_wr_req, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
